// File: rtl/matld_pkg.sv
// Shared types and sizing helpers for the matrix_mult operand loader.
package matld_pkg;

    typedef enum logic [2:0] {
        LOAD,
        START,
        GAP,
        STREAM,
        WAIT_DONE
    } matld_state_e;

    function automatic int unsigned matld_depth(input int unsigned m, input int unsigned n);
        return 2 * m * n;
    endfunction

    // Counters must be able to hold DEPTH itself, not just DEPTH-1.
    function automatic int unsigned matld_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned matld_addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/matld_buf.sv
// Operand buffer: simple dual-port RAM, one synchronous write and one synchronous read port.
module matld_buf #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/matrix_input_loader.sv
// Buffers A and B from a valid/ready host stream, then replays them to matrix_mult.
// Define MATLD_WAIT_DONE_EN to hold off new loads until matrix_mult reports done.
module matrix_input_loader
    import matld_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned M       = 8,
    parameter int unsigned N       = 8,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mm_start,
    output logic [DW-1:0] mm_data,
    input  logic          mm_done,
    output logic          busy
);

    localparam int unsigned DEPTH = matld_depth(M, N);
    localparam int unsigned CW    = matld_cnt_w(DEPTH);
    localparam int unsigned AW    = matld_addr_w(DEPTH);

    localparam logic [CW-1:0] LAST     = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    matld_state_e  state;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] gap_cnt;

    logic          wr_en_c;
    logic          load_c;
    logic [CW-1:0] rd_next_c;
    logic [AW-1:0] rd_addr_c;
    logic [DW-1:0] rd_data;

    assign wr_en_c = (state == LOAD) && in_valid && in_ready;

    // The RAM is addressed with the next pointer so rd_data always equals mem[rd_ptr].
    always_comb begin
        load_c = 1'b0;
        case (state)
            START:   load_c = (GAP_CYC == 0);
            GAP:     load_c = (gap_cnt == GAP_LAST);
            STREAM:  load_c = (rd_ptr != FULL);
            default: load_c = 1'b0;
        endcase

        rd_next_c = rd_ptr;
        if (reset) begin
            rd_next_c = '0;
        end else if (load_c) begin
            rd_next_c = rd_ptr + CW'(1);
        end else if (state == STREAM) begin
            rd_next_c = '0;
        end
        rd_addr_c = (rd_next_c == FULL) ? '0 : AW'(rd_next_c);
    end

    matld_buf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (AW'(wr_ptr)),
        .wr_data (in_data),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            gap_cnt  <= '0;
            in_ready <= 1'b1;
            mm_start <= 1'b0;
            mm_data  <= '0;
            busy     <= 1'b0;
        end else begin
            rd_ptr <= rd_next_c;
            if (load_c) begin
                mm_data <= rd_data;
            end
            case (state)
                LOAD: begin
                    if (wr_en_c) begin
                        if (wr_ptr == LAST) begin
                            wr_ptr   <= '0;
                            state    <= START;
                            mm_start <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + CW'(1);
                        end
                    end
                end
                START: begin
                    mm_start <= 1'b0;
                    state    <= (GAP_CYC == 0) ? STREAM : GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= STREAM;
                    end else begin
                        gap_cnt <= gap_cnt + CW'(1);
                    end
                end
                STREAM: begin
                    if (rd_ptr == FULL) begin
`ifdef MATLD_WAIT_DONE_EN
                        state    <= WAIT_DONE;
`else
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
`endif
                    end
                end
`ifdef MATLD_WAIT_DONE_EN
                WAIT_DONE: begin
                    if (mm_done) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= LOAD;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifndef MATLD_WAIT_DONE_EN
    logic unused_mm_done;
    assign unused_mm_done = mm_done;
`endif

endmodule

// File: tb/tb_matrix_input_loader.sv
// Scoreboard bench for matrix_input_loader: GAP_CYC=1 and GAP_CYC=0 instances, M=3, N=4, DW=8.
module tb_matrix_input_loader;

    localparam int unsigned DW    = 8;
    localparam int unsigned M     = 3;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 2 * M * N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          mm_done = 1'b0;
    logic          use0 = 1'b0;

    logic          rdy1, start1, busy1;
    logic [DW-1:0] data1;
    logic          rdy0, start0, busy0;
    logic [DW-1:0] data0;

    logic          s_ready, s_start, s_busy;
    logic [DW-1:0] s_data;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    matrix_input_loader #(.DW(DW), .M(M), .N(N), .GAP_CYC(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid && !use0),
        .in_ready (rdy1),
        .mm_start (start1),
        .mm_data  (data1),
        .mm_done  (mm_done),
        .busy     (busy1)
    );

    matrix_input_loader #(.DW(DW), .M(M), .N(N), .GAP_CYC(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid && use0),
        .in_ready (rdy0),
        .mm_start (start0),
        .mm_data  (data0),
        .mm_done  (mm_done),
        .busy     (busy0)
    );

    assign s_ready = use0 ? rdy0   : rdy1;
    assign s_start = use0 ? start0 : start1;
    assign s_busy  = use0 ? busy0  : busy1;
    assign s_data  = use0 ? data0  : data1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offer 24 words (0..11, 0..11), valid every 'every' cycles; push each accepted word.
    task automatic load_job(input int every);
        int sent = 0;
        int cyc  = 0;
        while (sent < int'(DEPTH) && cyc < 400) begin
            @(negedge clk);
            check("load_nostart", 32'(s_start), 32'(0));
            in_valid = ((cyc % every) == 0);
            in_data  = DW'(sent % int'(M * N));
            if (in_valid && s_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            cyc++;
        end
        check("load_done", 32'(sent), 32'(DEPTH));
    endtask

    task automatic expect_stream(input int gap, input bit flood, input int abort_at);
        int waited = 0;
        logic [DW-1:0] exp;
        logic [DW-1:0] last;
        last = '0;
        @(negedge clk);
        in_valid = flood;
        in_data  = 8'hFF;
        while (!s_start && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("start_seen", 32'(s_start), 32'(1));
        check("start_latency", 32'(waited), 32'(0));
        if (!s_start) begin
            exp_q.delete();
            in_valid = 1'b0;
            return;
        end
        check("start_busy", 32'(s_busy), 32'(1));
        check("start_ready", 32'(s_ready), 32'(0));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_nostart", 32'(s_start), 32'(0));
            check("gap_ready", 32'(s_ready), 32'(0));
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'(0), 32'(1));
                exp = '0;
            end else begin
                exp = exp_q.pop_front();
            end
            check("elem", 32'(s_data), 32'(exp));
            check("elem_nostart", 32'(s_start), 32'(0));
            check("elem_ready", 32'(s_ready), 32'(0));
            last = exp;
            if (k == abort_at) begin
                reset    = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check("rst_start", 32'(s_start), 32'(0));
                check("rst_data", 32'(s_data), 32'(0));
                check("rst_ready", 32'(s_ready), 32'(1));
                check("rst_busy", 32'(s_busy), 32'(0));
                reset = 1'b0;
                exp_q.delete();
                return;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("tail_hold", 32'(s_data), 32'(last));
`ifdef MATLD_WAIT_DONE_EN
        check("wait_ready", 32'(s_ready), 32'(0));
        check("wait_busy", 32'(s_busy), 32'(1));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("wait_ready", 32'(s_ready), 32'(0));
        end
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        check("done_ready", 32'(s_ready), 32'(1));
        check("done_busy", 32'(s_busy), 32'(0));
`else
        check("tail_ready", 32'(s_ready), 32'(1));
        check("tail_busy", 32'(s_busy), 32'(0));
`endif
        check("sb_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready1", 32'(rdy1), 32'(1));
        check("rst_start1", 32'(start1), 32'(0));
        check("rst_data1", 32'(data1), 32'(0));
        check("rst_busy1", 32'(busy1), 32'(0));
        check("rst_ready0", 32'(rdy0), 32'(1));
        check("rst_busy0", 32'(busy0), 32'(0));
        reset = 1'b0;

        load_job(1);
        expect_stream(1, 1'b0, -1);

        load_job(2);
        expect_stream(1, 1'b0, -1);

        load_job(1);
        expect_stream(1, 1'b1, -1);

        load_job(1);
        expect_stream(1, 1'b0, 5);
        load_job(1);
        expect_stream(1, 1'b0, -1);

        use0 = 1'b1;
        load_job(1);
        expect_stream(0, 1'b0, -1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
